// File: rtl/oppm_pkg.sv
// Definitions shared by the OPPM encoder and decoder: FSM states and the
// frame-geometry helpers both ends use to agree on symbol period and length.
package oppm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREAM = 2'd1,
    DATA  = 2'd2
  } state_e;

  function automatic int symbol_period(input int n_mod, input int l);
    return (1 << n_mod) * l;
  endfunction

  function automatic int data_symbols(input int n_pkt, input int n_mod);
    return n_pkt / n_mod;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings the asynchronous pulse into the clk domain and emits a registered
// one-cycle strobe on each rising edge.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic rise
);

  logic [2:0] sync_q, sync_d;
  logic       rise_q, rise_d;

  // Bits 0/1 are the metastability pair; bit 2 is the delayed copy for edge detect.
  always_comb begin
    sync_d = {sync_q[1:0], pulse};
    rise_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/oppm_decoder.sv
// OPPM receiver: locks onto the all-zero preamble, demodulates one PPM symbol
// per period on a slot grid anchored to the last preamble edge, and strobes out packets.
module oppm_decoder
  import oppm_pkg::*;
#(
  parameter int N_MOD    = 2,
  parameter int L        = 4,
  parameter int N_PKT    = 8,
  parameter int PRE_CT   = 3,
  parameter int PULSE_CT = 1,
  parameter int TOL      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  output logic [N_PKT-1:0] data,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  localparam int P     = symbol_period(N_MOD, L);
  localparam int G     = L / 2;
  localparam int D_CT  = data_symbols(N_PKT, N_MOD);
  localparam int SLOTS = 1 << N_MOD;
  localparam int T_W   = $clog2(P + TOL + 2);
  localparam int PC_W  = $clog2(PRE_CT + 1);
  localparam int SC_W  = $clog2(D_CT + 1);
  localparam int CT_W  = $clog2(L);

  localparam logic [T_W-1:0]   T_LO     = T_W'(P - TOL);
  localparam logic [T_W-1:0]   T_HI     = T_W'(P + TOL);
  localparam logic [PC_W-1:0]  PRE_LAST = PC_W'(PRE_CT);
  localparam logic [SC_W-1:0]  SYM_LAST = SC_W'(D_CT - 1);
  localparam logic [CT_W-1:0]  CT_LAST  = CT_W'(L - 1);
  localparam logic [CT_W-1:0]  CT_GUARD = CT_W'(G);
  localparam logic [N_MOD-1:0] IDX_LAST = N_MOD'(SLOTS - 1);

  if (N_PKT % N_MOD != 0) begin : g_chk_pkt
    $error("N_PKT must be a multiple of N_MOD");
  end
  if (L < 2 || PULSE_CT >= L) begin : g_chk_slot
    $error("need L >= 2 and PULSE_CT < L");
  end
  if (TOL >= L / 2) begin : g_chk_tol
    $error("TOL must be below L/2");
  end

  logic rise;

  edge_sync u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pulse (pulse),
    .rise  (rise)
  );

  state_e           state_q, state_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [PC_W-1:0]  pre_cnt_q, pre_cnt_d, pc_next;
  logic [CT_W-1:0]  slot_ct_q, slot_ct_d;
  logic [N_MOD-1:0] slot_idx_q, slot_idx_d;
  logic [SC_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic             first_q, first_d;
  logic             captured_q, captured_d;
  logic [N_MOD-1:0] sym_q, sym_d;
  logic [N_PKT-1:0] sr_q, sr_d, sr_next;
  logic [N_PKT-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             win_close;

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    pre_cnt_d  = pre_cnt_q;
    slot_ct_d  = slot_ct_q;
    slot_idx_d = slot_idx_q;
    sym_cnt_d  = sym_cnt_q;
    first_d    = first_q;
    captured_d = captured_q;
    sym_d      = sym_q;
    sr_d       = sr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    pc_next    = PC_W'(1);
    sr_next    = N_PKT'({sr_q, sym_q});
    win_close  = (slot_idx_q == IDX_LAST) && (slot_ct_q == CT_LAST);

    case (state_q)
      IDLE, PREAM: begin
        // t holds ticks since the last accepted edge; timeout wins over a coincident edge.
        if (state_q == PREAM && t_q > T_HI) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          if (state_q == PREAM && t_q >= T_LO) pc_next = pre_cnt_q + PC_W'(1);
          pre_cnt_d = pc_next;
          t_d       = T_W'(1);
          if (pc_next == PRE_LAST) begin
            state_d    = DATA;
            slot_ct_d  = CT_GUARD;
            slot_idx_d = '0;
            sym_cnt_d  = '0;
            first_d    = 1'b1;
            captured_d = 1'b0;
          end else begin
            state_d = PREAM;
          end
        end else if (state_q == PREAM) begin
          t_d = t_q + T_W'(1);
        end
      end

      DATA: begin
        if (slot_ct_q == CT_LAST) begin
          slot_ct_d  = '0;
          slot_idx_d = slot_idx_q + N_MOD'(1);
        end else begin
          slot_ct_d = slot_ct_q + CT_W'(1);
        end
        // An edge on the closing tick is slot 0 of the following window.
        if (win_close) begin
          captured_d = rise;
          sym_d      = '0;
          if (first_q) begin
            first_d = 1'b0;
          end else if (captured_q) begin
            sr_d      = sr_next;
            sym_cnt_d = sym_cnt_q + SC_W'(1);
            if (sym_cnt_q == SYM_LAST) begin
              data_d  = sr_next;
              valid_d = 1'b1;
              state_d = IDLE;
            end
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (rise && !captured_q && !first_q) begin
          captured_d = 1'b1;
          sym_d      = slot_idx_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      t_q        <= '0;
      pre_cnt_q  <= '0;
      slot_ct_q  <= '0;
      slot_idx_q <= '0;
      sym_cnt_q  <= '0;
      first_q    <= 1'b0;
      captured_q <= 1'b0;
      sym_q      <= '0;
      sr_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      pre_cnt_q  <= pre_cnt_d;
      slot_ct_q  <= slot_ct_d;
      slot_idx_q <= slot_idx_d;
      sym_cnt_q  <= sym_cnt_d;
      first_q    <= first_d;
      captured_q <= captured_d;
      sym_q      <= sym_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule
